// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, canonical NOP and fetch queue entry.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } fetch_entry_t;
endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read handshake: request/ready out, in-order rvalid/rdata back.
interface if_stage_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; flush wins over a same-cycle push.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop)  rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues credit-limited imem reads, queues returned words
// with their PC/PC+4, and presents the queue head to IF/ID.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hazard_detection,
    input  logic            NextPCSrc,
    input  logic [XLEN-1:0] branch_target,
    if_stage_if.master      imem,
    output logic            fetch_valid,
    output logic [XLEN-1:0] instruction_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] sum_out
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc, tag_pc;
    logic [CW-1:0]   inflight, discard_cnt, q_count, tag_count;
    logic            q_empty, q_full, tag_full, tag_empty;
    logic            accept, rsp, keep, pop;
    fetch_entry_t    q_din, q_head;
    logic            fifo_unused;

    assign pop = fetch_valid && !hazard_detection && !NextPCSrc;
    // The head leaving this cycle frees its slot now, so zero-wait memory sustains one fetch per cycle.
    assign imem.imem_req  = !NextPCSrc && ((int'(q_count) + int'(inflight) - int'(pop)) < DEPTH);
    assign imem.imem_addr = fetch_pc;
    assign accept = imem.imem_req && imem.imem_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp    = imem.imem_rvalid && (inflight != '0);
    assign keep   = rsp && (discard_cnt == '0) && !NextPCSrc;
    assign q_din  = '{instr: imem.imem_rdata, pc: tag_pc, pc4: tag_pc + 32'd4};

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk(clk), .rst(rst), .flush(1'b0),
        .push(accept), .din(fetch_pc), .pop(rsp), .dout(tag_pc),
        .count(tag_count), .full(tag_full), .empty(tag_empty)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_q (
        .clk(clk), .rst(rst), .flush(NextPCSrc),
        .push(keep), .din(q_din), .pop(pop), .dout(q_head),
        .count(q_count), .full(q_full), .empty(q_empty)
    );

    assign fifo_unused = &{1'b0, tag_count, tag_full, tag_empty, q_full};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= '0;
            discard_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(accept) - CW'(rsp);
            if (NextPCSrc) begin
                fetch_pc    <= {branch_target[XLEN-1:2], 2'b00};
                discard_cnt <= inflight - CW'(rsp);
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (rsp && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
            end
        end
    end

    assign fetch_valid     = !q_empty;
    assign instruction_out = fetch_valid ? q_head.instr : NOP_INSTR;
    assign pc_out          = fetch_valid ? q_head.pc    : '0;
    assign sum_out         = fetch_valid ? q_head.pc4   : '0;
endmodule

// File: tb/tb_if_stage.sv
// Directed-vector and scoreboard bench for if_stage with a behavioural in-order instruction memory.
module tb_if_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        hazard, npc;
    logic [31:0] target;
    logic        fv, fv2;
    logic [31:0] instr, pc, sum, instr2, pc2, sum2;

    if_stage_if bus();
    if_stage_if bus2();

    if_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .hazard_detection(hazard), .NextPCSrc(npc),
        .branch_target(target), .imem(bus), .fetch_valid(fv),
        .instruction_out(instr), .pc_out(pc), .sum_out(sum)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .hazard_detection(1'b0), .NextPCSrc(1'b0),
        .branch_target(32'h0), .imem(bus2), .fetch_valid(fv2),
        .instruction_out(instr2), .pc_out(pc2), .sum_out(sum2)
    );

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Memory for the main DUT: in-order, per-request latency, optional hold of responses.
    int          cyc = 0;
    int          mem_lat = 1;
    bit          mem_hold = 1'b0;
    logic [31:0] pq_addr [$];
    int          pq_due  [$];

    always @(posedge clk) begin
        if (rst) begin
            pq_addr.delete();
            pq_due.delete();
            bus.imem_rvalid <= 1'b0;
            bus.imem_rdata  <= '0;
        end else begin
            if (bus.imem_req && bus.imem_ready) begin
                pq_addr.push_back(bus.imem_addr);
                pq_due.push_back(cyc + mem_lat);
            end
            if (!mem_hold && pq_addr.size() > 0 && pq_due[0] <= cyc + 1) begin
                bus.imem_rvalid <= 1'b1;
                bus.imem_rdata  <= f(pq_addr[0]);
                void'(pq_addr.pop_front());
                void'(pq_due.pop_front());
            end else begin
                bus.imem_rvalid <= 1'b0;
            end
        end
        cyc++;
    end

    // Zero-wait memory for the wrap-around instance.
    assign bus2.imem_ready = 1'b1;
    always @(posedge clk) begin
        bus2.imem_rvalid <= !rst && bus2.imem_req;
        bus2.imem_rdata  <= f(bus2.imem_addr);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          haz, npc, hold;
        logic [31:0] tgt;
        bit          e_v;
        logic [31:0] e_pc;
        bit          e_req;
        logic [31:0] e_addr;
    } vec_t;

    function automatic vec_t mk(bit h, bit n, bit hd, logic [31:0] t,
                                bit v, logic [31:0] p, bit rq, logic [31:0] ad);
        vec_t r;
        r.haz = h; r.npc = n; r.hold = hd; r.tgt = t;
        r.e_v = v; r.e_pc = p; r.e_req = rq; r.e_addr = ad;
        return r;
    endfunction

    vec_t        tbl [20];
    logic [31:0] r2  [4];
    logic [31:0] e_instr, e_sum, exp_pc, prev_pc;
    bit          prev_stall;
    int          pops;

    initial begin
        // cycle 0 = first cycle after reset release; zero-wait memory unless hold is set
        tbl[0]  = mk(0,0,0,32'h0,   0,32'h0,   1,32'h0);
        tbl[1]  = mk(0,0,0,32'h0,   0,32'h0,   1,32'h4);
        tbl[2]  = mk(0,0,0,32'h0,   1,32'h0,   1,32'h8);
        tbl[3]  = mk(0,0,0,32'h0,   1,32'h4,   1,32'hC);
        tbl[4]  = mk(1,0,0,32'h0,   1,32'h8,   0,32'h10);
        tbl[5]  = mk(1,0,0,32'h0,   1,32'h8,   0,32'h10);
        tbl[6]  = mk(1,0,0,32'h0,   1,32'h8,   0,32'h10);
        tbl[7]  = mk(0,0,0,32'h0,   1,32'h8,   1,32'h10);
        tbl[8]  = mk(0,0,0,32'h0,   1,32'hC,   1,32'h14);
        tbl[9]  = mk(0,0,1,32'h0,   1,32'h10,  1,32'h18);
        tbl[10] = mk(0,0,1,32'h0,   1,32'h14,  1,32'h1C);
        tbl[11] = mk(0,1,0,32'h100, 0,32'h0,   0,32'h20);
        tbl[12] = mk(0,0,0,32'h0,   0,32'h0,   0,32'h100);
        tbl[13] = mk(0,0,0,32'h0,   0,32'h0,   1,32'h100);
        tbl[14] = mk(0,0,0,32'h0,   0,32'h0,   1,32'h104);
        tbl[15] = mk(0,0,0,32'h0,   1,32'h100, 1,32'h108);
        tbl[16] = mk(0,1,0,32'h203, 1,32'h104, 0,32'h10C);
        tbl[17] = mk(0,0,0,32'h0,   0,32'h0,   1,32'h200);
        tbl[18] = mk(0,0,0,32'h0,   0,32'h0,   1,32'h204);
        tbl[19] = mk(0,0,0,32'h0,   1,32'h200, 1,32'h208);
        r2[0] = 32'hFFFF_FFF8; r2[1] = 32'hFFFF_FFFC; r2[2] = 32'h0; r2[3] = 32'h4;

        hazard = 1'b0; npc = 1'b0; target = '0; bus.imem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", {31'b0, fv}, 32'h0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_pc", pc, 32'h0);
        chk("rst_sum", sum, 32'h0);

        for (int i = 0; i < 20; i++) begin
            rst = 1'b0;
            hazard = tbl[i].haz; npc = tbl[i].npc; target = tbl[i].tgt; mem_hold = tbl[i].hold;
            #1;
            e_instr = tbl[i].e_v ? f(tbl[i].e_pc) : NOP_INSTR;
            e_sum   = tbl[i].e_v ? tbl[i].e_pc + 32'd4 : 32'h0;
            chk($sformatf("v%0d_valid", i), {31'b0, fv}, {31'b0, tbl[i].e_v});
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_sum", i), sum, e_sum);
            chk($sformatf("v%0d_instr", i), instr, e_instr);
            chk($sformatf("v%0d_req", i), {31'b0, bus.imem_req}, {31'b0, tbl[i].e_req});
            chk($sformatf("v%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
            @(negedge clk);
        end

        // PC wrap-around on the second instance
        rst = 1'b1; hazard = 1'b0; npc = 1'b0; mem_hold = 1'b0; mem_lat = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c >= 2) begin
                e_sum = r2[c-2] + 32'd4;
                chk($sformatf("wrap%0d_valid", c), {31'b0, fv2}, 32'h1);
                chk($sformatf("wrap%0d_pc", c), pc2, r2[c-2]);
                chk($sformatf("wrap%0d_sum", c), sum2, e_sum);
                chk($sformatf("wrap%0d_instr", c), instr2, f(r2[c-2]));
            end else begin
                chk($sformatf("wrap%0d_valid", c), {31'b0, fv2}, 32'h0);
                chk($sformatf("wrap%0d_instr", c), instr2, NOP_INSTR);
            end
            @(negedge clk);
        end

        // Random ready/latency/stalls/redirects with a reset mid-burst
        exp_pc = 32'h0; prev_pc = 32'h0; prev_stall = 1'b0; pops = 0;
        for (int c = 0; c < 800; c++) begin
            rst    = (c == 0 || c == 400);
            hazard = (c != 401) && ($urandom_range(0, 3) == 0);
            npc    = (c != 401) && ($urandom_range(0, 19) == 0);
            target = $urandom;
            bus.imem_ready = (c == 401) || ($urandom_range(0, 2) != 0);
            mem_lat = $urandom_range(1, 4);
            #1;
            if (rst) begin
                exp_pc = 32'h0;
                prev_stall = 1'b0;
            end else begin
                if (c == 401) begin
                    chk("midrst_valid", {31'b0, fv}, 32'h0);
                    chk("midrst_instr", instr, NOP_INSTR);
                    chk("midrst_pc", pc, 32'h0);
                    chk("midrst_sum", sum, 32'h0);
                    chk("midrst_req", {31'b0, bus.imem_req}, 32'h1);
                    chk("midrst_addr", bus.imem_addr, 32'h0);
                end
                if (prev_stall) begin
                    chk("stall_valid", {31'b0, fv}, 32'h1);
                    chk("stall_pc", pc, prev_pc);
                end
                if (fv && !hazard && !npc) begin
                    e_sum = exp_pc + 32'd4;
                    chk("sb_pc", pc, exp_pc);
                    chk("sb_sum", sum, e_sum);
                    chk("sb_instr", instr, f(exp_pc));
                    exp_pc = e_sum;
                    pops++;
                end
                if (!fv) chk("sb_empty_instr", instr, NOP_INSTR);
                if (npc) exp_pc = {target[31:2], 2'b00};
                prev_stall = fv && hazard && !npc;
                prev_pc = pc;
            end
            @(negedge clk);
        end
        chk("progress", {31'b0, (pops >= 60)}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RISC-V pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, issues word reads to instruction memory over a request/response handshake, and buffers returned words with their PC and PC+4 in a small in-order queue. Presents the queue head to IF/ID as instruction/pc/pc+4, holding it under hazard stalls and flushing on a taken-branch redirect.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset
- DEPTH, 2: instruction-queue entries; also the maximum number of requests in flight
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hazard_detection  in  1  stall from the hazard unit: hold the head, do not pop
- NextPCSrc  in  1  taken branch/jump: redirect fetch
- branch_target  in  32  redirect address, valid when NextPCSrc=1
- imem_req  out  1  read request valid
- imem_addr  out  32  word address of the request
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid, responses in request order
- imem_rdata  in  32  instruction word
- fetch_valid  out  1  queue head valid
- instruction_out  out  32  head instruction; NOP 32'h0000_0013 when empty
- pc_out  out  32  head PC; 0 when empty
- sum_out  out  32  head PC+4; 0 when empty

## Operation
- fetch_pc register; imem_addr = fetch_pc.
- imem_req = !NextPCSrc && (q_count + inflight < DEPTH) (credit scheme: every issued request has a reserved queue slot, so the queue never overflows).
- Accept = imem_req && imem_ready: push fetch_pc into tag FIFO, fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Response (imem_rvalid): pop tag; if discard_cnt > 0, decrement discard_cnt and drop the word; else push {rdata, tag, tag+4} into the instruction queue.
- Pop: fetch_valid && !hazard_detection && !NextPCSrc.
- Redirect (NextPCSrc=1): instruction queue cleared; fetch_pc <= {branch_target[31:2], 2'b00}; discard_cnt <= inflight minus any response consumed this cycle; no request issued this cycle.
- imem_rvalid with no request in flight is a protocol error: ignored, no state change.
- Outputs are combinational from queue head; empty queue drives NOP/0/0 with fetch_valid=0.

## Timing
- Reset: fetch_pc=RESET_PC, queue and tag FIFO empty, inflight=0, discard_cnt=0; outputs fetch_valid=0, instruction_out=32'h0000_0013, pc_out=0, sum_out=0; imem_req=1 in the first cycle after reset release. Instruction memory shares rst, so no stale responses survive reset; reset mid-operation discards everything.
- Memory latency ≥1 cycle (rvalid no earlier than the cycle after accept); variable latency permitted.
- Zero-wait memory at steady state, DEPTH=2: one instruction per cycle; first fetch_valid two cycles after reset release.
- Same-cycle push and pop: allowed; q_count unchanged.
- Priority: rst > NextPCSrc > hazard_detection > normal pop.
- First post-redirect word is visible no earlier than the cycle after its response, after all discarded responses drain.
- Stall with full queue: imem_req=0 until a pop frees a credit; head values are stable throughout the stall.

## Structure
- Shared package riscv_pkg: XLEN=32, NOP_INSTR=32'h0000_0013, default RESET_PC.
- One sub-module, fetch_fifo (parameterised width/depth synchronous FIFO with flush, count, full/empty), instantiated twice: tag FIFO (32 b) and instruction queue (96 b).
- inflight and discard_cnt are $clog2(DEPTH+1)-bit counters in if_stage.

## Test plan
- Reset, zero-wait memory returning addr-derived words, no stalls -> pc_out sequence 0,4,8,12 on consecutive cycles, sum_out = pc_out+4, fetch_valid stays 1.
- hazard_detection held 3 cycles while pc_out=8 -> outputs frozen at pc 8, imem_req drops once queue+inflight=2, pc 12 appears the cycle after release.
- NextPCSrc with branch_target=32'h100 while two requests in flight -> both in-flight responses dropped, next fetch_valid shows pc_out=32'h100, sum_out=32'h104.
- Redirect to 32'h0000_0203 -> next imem_addr=32'h0000_0200.
- RESET_PC=32'hFFFF_FFF8 -> pc_out FFFF_FFF8, FFFF_FFFC, 0, 4; sum_out for FFFF_FFFC is 0.
- Random imem_ready/latency 1-4 cycles, random stalls, rst asserted mid-burst -> outputs NOP/0/0 next cycle, fetch restarts at RESET_PC, scoreboard shows no lost, duplicated or reordered instruction.
